// File: rtl/handshake_protocol_monitor.sv
// rtl/handshake_protocol_monitor.sv - observe-only ready/valid protocol checker for N channels
//
// Purpose: watches N_CH ready/valid channels and enforces three rules:
//   - valid must not be withdrawn before the transfer completes,
//   - the payload must not change while a transfer is pending,
//   - a pending transfer must not stall more than MAX_STALL cycles.
// It keeps saturating transfer counters, sticky error flags and a
// first-error record. It never drives the monitored design.
//
// Ports:
//   CLK, RESET        clock, synchronous active-high reset
//   enable            checking/counting enable
//   clear             synchronous clear, same effect as RESET
//   valid, ready      per-channel handshake signals
//   data              per-channel payload, channel i at [i*DATA_W +: DATA_W]
//   xfer_count        per-channel saturating counters, channel i at [i*CNT_W +: CNT_W]
//   err_drop/data/stall  sticky per-channel violation flags
//   any_err           OR of all sticky flags
//   first_err_*       channel and code of the first violation (01 drop, 10 data, 11 stall)
module handshake_protocol_monitor #(
  parameter int N_CH      = 3,
  parameter int DATA_W    = 5,
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 8,
  parameter int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     enable,
  input  logic                     clear,
  input  logic [N_CH-1:0]          valid,
  input  logic [N_CH-1:0]          ready,
  input  logic [N_CH*DATA_W-1:0]   data,
  output logic [N_CH*CNT_W-1:0]    xfer_count,
  output logic [N_CH-1:0]          err_drop,
  output logic [N_CH-1:0]          err_data,
  output logic [N_CH-1:0]          err_stall,
  output logic                     any_err,
  output logic                     first_err_valid,
  output logic [CH_W-1:0]          first_err_chan,
  output logic [1:0]               first_err_code
);

  typedef enum logic {S_IDLE, S_PENDING} state_e;

  // Stall counter only needs to reach MAX_STALL+1, where it parks.
  localparam int              SW        = $clog2(MAX_STALL + 2);
  localparam logic [SW-1:0]   STALL_MAX = SW'(MAX_STALL);
  localparam logic [SW-1:0]   STALL_SAT = SW'(MAX_STALL + 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  state_e            state_q [N_CH];
  state_e            state_d [N_CH];
  logic [DATA_W-1:0] cap_q   [N_CH];
  logic [DATA_W-1:0] cap_d   [N_CH];
  logic [SW-1:0]     stall_q [N_CH];
  logic [SW-1:0]     stall_d [N_CH];
  logic [CNT_W-1:0]  cnt_q   [N_CH];
  logic [CNT_W-1:0]  cnt_d   [N_CH];

  logic [N_CH-1:0] drop_q, drop_d, dchg_q, dchg_d, stl_q, stl_d;
  logic [N_CH-1:0] ev_drop, ev_data, ev_stall;
  logic            any_q, any_d;
  logic            fv_q, fv_d;
  logic [CH_W-1:0] fch_q, fch_d;
  logic [1:0]      fcode_q, fcode_d;

  always_comb begin
    state_d  = state_q;
    cap_d    = cap_q;
    stall_d  = stall_q;
    cnt_d    = cnt_q;
    ev_drop  = '0;
    ev_data  = '0;
    ev_stall = '0;

    for (int i = 0; i < N_CH; i++) begin
      if (!enable) begin
        // Disabling abandons any handshake in progress without error.
        state_d[i] = S_IDLE;
        stall_d[i] = '0;
      end else begin
        case (state_q[i])
          S_IDLE: begin
            if (valid[i] && ready[i]) begin
              cnt_d[i] = (cnt_q[i] != CNT_SAT) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
            end else if (valid[i]) begin
              cap_d[i]   = data[i*DATA_W +: DATA_W];
              stall_d[i] = SW'(1);
              state_d[i] = S_PENDING;
            end
          end
          S_PENDING: begin
            if (!valid[i]) begin
              ev_drop[i] = 1'b1;
              state_d[i] = S_IDLE;
              stall_d[i] = '0;
            end else begin
              // Capture is never refreshed, so each differing cycle is flagged.
              if (data[i*DATA_W +: DATA_W] != cap_q[i]) ev_data[i] = 1'b1;
              if (ready[i]) begin
                cnt_d[i]   = (cnt_q[i] != CNT_SAT) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
                state_d[i] = S_IDLE;
                stall_d[i] = '0;
              end else begin
                if (stall_q[i] != STALL_SAT) stall_d[i] = stall_q[i] + SW'(1);
                // Fires only on the step MAX_STALL -> MAX_STALL+1: once per episode.
                if ((MAX_STALL != 0) && (stall_q[i] == STALL_MAX)) ev_stall[i] = 1'b1;
              end
            end
          end
          default: state_d[i] = S_IDLE;
        endcase
      end
    end

    drop_d = drop_q | ev_drop;
    dchg_d = dchg_q | ev_data;
    stl_d  = stl_q  | ev_stall;
    any_d  = |{drop_d, dchg_d, stl_d};

    fv_d    = fv_q;
    fch_d   = fch_q;
    fcode_d = fcode_q;
    if (!fv_q) begin
      // Walk downward so the lowest-indexed offending channel wins.
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (ev_drop[i] || ev_data[i] || ev_stall[i]) begin
          fv_d    = 1'b1;
          fch_d   = CH_W'(i);
          fcode_d = ev_stall[i] ? 2'b11 : (ev_data[i] ? 2'b10 : 2'b01);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET || clear) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= S_IDLE;
        cap_q[i]   <= '0;
        stall_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
      drop_q  <= '0;
      dchg_q  <= '0;
      stl_q   <= '0;
      any_q   <= 1'b0;
      fv_q    <= 1'b0;
      fch_q   <= '0;
      fcode_q <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      stall_q <= stall_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      dchg_q  <= dchg_d;
      stl_q   <= stl_d;
      any_q   <= any_d;
      fv_q    <= fv_d;
      fch_q   <= fch_d;
      fcode_q <= fcode_d;
    end
  end

  always_comb begin
    xfer_count = '0;
    for (int i = 0; i < N_CH; i++) xfer_count[i*CNT_W +: CNT_W] = cnt_q[i];
  end

  assign err_drop        = drop_q;
  assign err_data        = dchg_q;
  assign err_stall       = stl_q;
  assign any_err         = any_q;
  assign first_err_valid = fv_q;
  assign first_err_chan  = fch_q;
  assign first_err_code  = fcode_q;

endmodule
